// File: rtl/cache_line_refill.sv
// Line-refill controller: fetches one cache line word by word from a 32-bit memory port.
// Optional one-entry line buffer enabled by defining CACHE_LINE_REFILL_LINEBUF_EN.
module cache_line_refill #(
   parameter  int unsigned NrWordsPerLine = 4,
   localparam int unsigned LineSize       = 32 * NrWordsPerLine
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                line_req_i,
   input  logic [31:0]         line_addr_i,
   output logic                line_valid_o,
   output logic [LineSize-1:0] line_data_o,
   output logic                word_req_o,
   output logic [31:0]         word_addr_o,
   input  logic                word_rvalid_i,
   input  logic [31:0]         word_rdata_i,
   output logic [1:0]          state_o
);

   localparam int unsigned OffBits = $clog2(LineSize / 8);
   localparam int unsigned KW      = $clog2(NrWordsPerLine);
   localparam logic [31:0] OffMask = 32'((64'd1 << OffBits) - 64'd1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e                state_q;
   logic [KW-1:0]         k_q;
   logic [31:0]           line_q;
   logic [LineSize-1:0]   data_q;
   logic                  word_req_q;
   logic [31:0]           word_addr_q;

   logic [31:0]           req_line;
   logic                  mismatch;
   logic                  beat;
   logic                  last_word;

   assign req_line  = line_addr_i & ~OffMask;
   assign mismatch  = !line_req_i || (req_line != line_q);
   assign beat      = word_rvalid_i && word_req_q;
   assign last_word = &k_q;

`ifdef CACHE_LINE_REFILL_LINEBUF_EN
   logic                  buf_valid_q;
   logic [31:0]           buf_addr_q;
   logic [LineSize-1:0]   buf_data_q;
   logic                  buf_hit;

   assign buf_hit = buf_valid_q && (buf_addr_q == req_line);
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= IDLE;
         k_q         <= '0;
         line_q      <= '0;
         data_q      <= '0;
         word_req_q  <= 1'b0;
         word_addr_q <= '0;
`ifdef CACHE_LINE_REFILL_LINEBUF_EN
         buf_valid_q <= 1'b0;
         buf_addr_q  <= '0;
         buf_data_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (line_req_i) begin
                  line_q <= req_line;
                  k_q    <= '0;
`ifdef CACHE_LINE_REFILL_LINEBUF_EN
                  if (buf_hit) begin
                     data_q  <= buf_data_q;
                     state_q <= DONE;
                  end else begin
                     state_q     <= FETCH;
                     word_req_q  <= 1'b1;
                     word_addr_q <= req_line;
                  end
`else
                  state_q     <= FETCH;
                  word_req_q  <= 1'b1;
                  word_addr_q <= req_line;
`endif
               end
            end
            FETCH: begin
               if (beat) begin
                  data_q[k_q*32 +: 32] <= word_rdata_i;
                  if (mismatch) begin
                     state_q    <= IDLE;
                     word_req_q <= 1'b0;
                  end else if (last_word) begin
                     state_q    <= DONE;
                     word_req_q <= 1'b0;
                  end else begin
                     k_q         <= k_q + 1'b1;
                     word_addr_q <= word_addr_q + 32'd4;
                  end
               end else if (mismatch) begin
                  // The outstanding word must still be consumed before going idle.
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (beat) begin
                  state_q    <= IDLE;
                  word_req_q <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
`ifdef CACHE_LINE_REFILL_LINEBUF_EN
               if (!mismatch) begin
                  buf_valid_q <= 1'b1;
                  buf_addr_q  <= line_q;
                  buf_data_q  <= data_q;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // The delivery pulse is suppressed in the same cycle the cache withdraws or retargets.
   assign line_valid_o = (state_q == DONE) && !mismatch;
   assign line_data_o  = data_q;
   assign word_req_o   = word_req_q;
   assign word_addr_o  = word_addr_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_cache_line_refill.sv
// Directed bench for cache_line_refill: vector table for a zero-wait fill plus
// hand-written sequences for waits, drain, retarget, reset and the optional line buffer.
module tb_cache_line_refill;

   localparam int N  = 4;
   localparam int LS = 32 * N;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          line_req_i = 1'b0;
   logic [31:0]   line_addr_i = '0;
   logic          line_valid_o;
   logic [LS-1:0] line_data_o;
   logic          word_req_o;
   logic [31:0]   word_addr_o;
   logic          word_rvalid_i = 1'b0;
   logic [31:0]   word_rdata_i = '0;
   logic [1:0]    state_o;

   cache_line_refill #(.NrWordsPerLine(N)) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .line_req_i    (line_req_i),
      .line_addr_i   (line_addr_i),
      .line_valid_o  (line_valid_o),
      .line_data_o   (line_data_o),
      .word_req_o    (word_req_o),
      .word_addr_o   (word_addr_o),
      .word_rvalid_i (word_rvalid_i),
      .word_rdata_i  (word_rdata_i),
      .state_o       (state_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        rv;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string name, input logic [LS-1:0] act, input logic [LS-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge and let outputs settle.
   task automatic step(input logic req, input logic [31:0] addr, input logic rv, input logic [31:0] rd);
      @(negedge clk_i);
      line_req_i    = req;
      line_addr_i   = addr;
      word_rvalid_i = rv;
      word_rdata_i  = rd;
      #1;
   endtask

   function automatic logic [LS-1:0] line_of(input logic [31:0] base);
      logic [LS-1:0] d;
      for (int i = 0; i < N; i++) d[32*i +: 32] = base + 32'(i);
      return d;
   endfunction

   // Full request with w wait cycles per word; vcyc is the cycle the pulse is expected.
   task automatic do_fill(input string tag, input logic [31:0] addr, input int w,
                          input logic [31:0] base, input int vcyc, input bit traffic);
      int nreq;
      nreq = 0;
      for (int c = 0; c <= vcyc + 1; c++) begin
         bit          ereq;
         bit          rv;
         int          j;
         logic [31:0] eaddr;
         ereq  = traffic && (c >= 1) && (c <= N * (w + 1));
         j     = ereq ? (c - 1) / (w + 1) : 0;
         rv    = ereq && (((c - 1) % (w + 1)) == w);
         eaddr = addr + 32'(4 * j);
         step(c <= vcyc, addr, rv, base + 32'(j));
         if (word_req_o) nreq++;
         chk({tag, " word_req"}, LS'(word_req_o), LS'(ereq));
         if (ereq) chk({tag, " word_addr"}, LS'(word_addr_o), LS'(eaddr));
         chk({tag, " line_valid"}, LS'(line_valid_o), LS'(c == vcyc));
      end
      chk({tag, " line_data"}, line_data_o, line_of(base));
      chk({tag, " req_cycles"}, LS'(nreq), LS'(traffic ? N * (w + 1) : 0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Zero-wait fill at 0x1230, cycle 0 = request seen.
      vt[0] = '{1'b1, 32'h1230, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0};
      vt[1] = '{1'b1, 32'h1230, 1'b1, 32'hA0, 1'b1, 32'h1230, 1'b0};
      vt[2] = '{1'b1, 32'h1230, 1'b1, 32'hA1, 1'b1, 32'h1234, 1'b0};
      vt[3] = '{1'b1, 32'h1230, 1'b1, 32'hA2, 1'b1, 32'h1238, 1'b0};
      vt[4] = '{1'b1, 32'h1230, 1'b1, 32'hA3, 1'b1, 32'h123C, 1'b0};
      vt[5] = '{1'b1, 32'h1230, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1};
      vt[6] = '{1'b0, 32'h1230, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0};

      #12;
      chk("rst line_valid", LS'(line_valid_o), '0);
      chk("rst word_req",   LS'(word_req_o),   '0);
      chk("rst word_addr",  LS'(word_addr_o),  '0);
      chk("rst line_data",  line_data_o,       '0);
      chk("rst state",      LS'(state_o),      '0);
      @(negedge clk_i);
      rstn_i = 1'b1;

      for (int i = 0; i < 7; i++) begin
         step(vt[i].req, vt[i].addr, vt[i].rv, vt[i].rd);
         chk($sformatf("vec%0d word_req", i), LS'(word_req_o), LS'(vt[i].e_req));
         if (vt[i].e_req) chk($sformatf("vec%0d word_addr", i), LS'(word_addr_o), LS'(vt[i].e_addr));
         chk($sformatf("vec%0d line_valid", i), LS'(line_valid_o), LS'(vt[i].e_valid));
      end
      chk("vec line_data", line_data_o, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

      do_fill("wait2", 32'h1230, 2, 32'hB0, 13, 1'b1);

      // Request drops while word 2 is pending: drain it, no pulse.
      step(1'b1, 32'h1230, 1'b0, 32'h0);
      chk("drain c0 word_req", LS'(word_req_o), '0);
      step(1'b1, 32'h1230, 1'b1, 32'hC0);
      chk("drain c1 word_addr", LS'(word_addr_o), LS'(32'h1230));
      step(1'b1, 32'h1230, 1'b1, 32'hC1);
      chk("drain c2 word_addr", LS'(word_addr_o), LS'(32'h1234));
      step(1'b0, 32'h1230, 1'b0, 32'h0);
      chk("drain c3 word_req", LS'(word_req_o), LS'(1'b1));
      chk("drain c3 line_valid", LS'(line_valid_o), '0);
      step(1'b0, 32'h1230, 1'b0, 32'h0);
      chk("drain c4 word_req", LS'(word_req_o), LS'(1'b1));
      chk("drain c4 word_addr", LS'(word_addr_o), LS'(32'h1238));
      chk("drain c4 state", LS'(state_o), LS'(2'd2));
      step(1'b0, 32'h1230, 1'b1, 32'hDEAD);
      chk("drain c5 word_req", LS'(word_req_o), LS'(1'b1));
      chk("drain c5 line_valid", LS'(line_valid_o), '0);
      step(1'b0, 32'h1230, 1'b0, 32'h0);
      chk("drain c6 word_req", LS'(word_req_o), '0);
      chk("drain c6 line_valid", LS'(line_valid_o), '0);
      chk("drain line_data", line_data_o, {32'hB3, 32'hB2, 32'hC1, 32'hC0});

      // Retarget 0x1230 -> 0x5670 on a beat: abort, then a fresh fill.
      step(1'b1, 32'h1230, 1'b0, 32'h0);
      step(1'b1, 32'h1230, 1'b1, 32'hD0);
      chk("retgt c1 word_addr", LS'(word_addr_o), LS'(32'h1230));
      chk("retgt c1 line_valid", LS'(line_valid_o), '0);
      step(1'b1, 32'h5670, 1'b1, 32'hD1);
      chk("retgt c2 word_addr", LS'(word_addr_o), LS'(32'h1234));
      chk("retgt c2 line_valid", LS'(line_valid_o), '0);
      do_fill("retgt", 32'h5670, 0, 32'hE0, 5, 1'b1);

      // Asynchronous reset in the middle of a fill.
      step(1'b1, 32'h3000, 1'b0, 32'h0);
      step(1'b1, 32'h3000, 1'b1, 32'hF0);
      step(1'b1, 32'h3000, 1'b1, 32'hF1);
      chk("midrst pre word_addr", LS'(word_addr_o), LS'(32'h3004));
      #1;
      rstn_i = 1'b0;
      #1;
      chk("midrst word_req",   LS'(word_req_o),   '0);
      chk("midrst word_addr",  LS'(word_addr_o),  '0);
      chk("midrst line_valid", LS'(line_valid_o), '0);
      chk("midrst line_data",  line_data_o,       '0);
      step(1'b0, 32'h0, 1'b0, 32'h0);
      rstn_i = 1'b1;
      do_fill("after_rst", 32'h2000, 0, 32'h20, 5, 1'b1);

      // Same line twice: buffer hit when enabled, full refetch otherwise.
      do_fill("first_1230", 32'h1230, 0, 32'h60, 5, 1'b1);
`ifdef CACHE_LINE_REFILL_LINEBUF_EN
      do_fill("hit_1230", 32'h1230, 0, 32'h60, 1, 1'b0);
`else
      do_fill("again_1230", 32'h1230, 0, 32'h70, 5, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_line_refill.md
# cache_line_refill

Line-refill controller sitting directly downstream of the instruction cache's memory read port. It accepts a line request (line-aligned address plus request level), fetches the line from a 32-bit word-wide memory one word at a time, and packs the words into a single line. It then returns the line to the cache with a one-cycle valid pulse. It aborts cleanly when the cache withdraws or retargets its request mid-fill.

## Interface
- NrWordsPerLine, 4: 32-bit words per cache line; must be a power of two ≥ 2.
- LineSize, 32*NrWordsPerLine: line width in bits (derived, not overridable).
- clk_i  in  1  clock, all state on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- line_req_i  in  1  cache miss request level (cache mem_read_en).
- line_addr_i  in  32  requested address; bits [log2(LineSize/8)-1:0] ignored.
- line_valid_o  out  1  one-cycle pulse: line_data_o holds the requested line.
- line_data_o  out  LineSize  assembled line; word k at bits [32k +: 32].
- word_req_o  out  1  memory word request level.
- word_addr_o  out  32  byte address of requested word (word-aligned).
- word_rvalid_i  in  1  memory word response; counted only while word_req_o=1.
- word_rdata_i  in  32  response data, sampled when word_rvalid_i & word_req_o.

## Operation
- Line address: line_addr_i with low log2(LineSize/8) bits forced to 0; latched into line_q on acceptance.
- Mismatch = line_req_i==0 OR line address of line_addr_i ≠ line_q.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: line_req_i=1 → latch line_q, beat counter k=0 → FETCH. Otherwise stay.
- FETCH: word_req_o=1, word_addr_o = line_q + 4k.
  - On a beat (word_rvalid_i=1), write word_rdata_i into word slot k.
  - On a beat with k<NrWordsPerLine-1 and no mismatch: k+1, stay in FETCH.
  - On a beat with k=NrWordsPerLine-1 and no mismatch: go to DONE.
  - Mismatch: if a beat completes in the same cycle → IDLE; if not → DRAIN.
- DRAIN: word_req_o stays 1 with the same word_addr_o until a beat arrives; that beat is discarded → IDLE. A request is never dropped without a response.
- DONE: no mismatch → line_valid_o=1 for this cycle only → IDLE. Mismatch → line_valid_o stays 0, go to IDLE (stale line never delivered).
- After DONE, return to IDLE. The cache deasserts its request the cycle after it writes, so no re-fetch occurs.
- k is a log2(NrWordsPerLine)-bit counter and wraps only via a state change; word_addr_o never crosses the line.
- line_data_o is a register: holds the last written words and is not cleared between fills.

## Timing
- Reset values (async, immediate):
  - state=IDLE, k=0, line_q=0, line_data_o=0.
  - line_valid_o=0, word_req_o=0, word_addr_o=0.
  - Line-buffer valid=0 when enabled.
- Reset mid-fill: abandons the transaction. The memory side must tolerate req dropping.
- Zero-wait memory (word_rvalid_i=1 whenever word_req_o=1): request seen at cycle 0, beats in cycles 1..4, line_valid_o in cycle 5 (NrWordsPerLine=4).
- With W wait cycles per word: line_valid_o at cycle 1 + NrWordsPerLine*(W+1).
- word_addr_o changes only on the clock edge following a beat.
- Only one word outstanding at any time.

## Configuration
- CACHE_LINE_REFILL_LINEBUF_EN defined:
  - A one-entry line buffer (address plus data) is captured whenever DONE delivers a line.
  - In IDLE, if line_req_i=1 and the buffer is valid with a matching line address: load line_data_o from the buffer and go to DONE with no memory traffic. line_valid_o fires in cycle 1.
  - The buffer valid bit is cleared only by reset.
- Undefined: no buffer; every request performs a full fetch.

## Test plan
- Zero-wait fill at 0x0000_1230: word_addr_o sequence 0x1230, 0x1234, 0x1238, 0x123C. Data 0xA0..0xA3 gives line_data_o = {0xA3,0xA2,0xA1,0xA0}, line_valid_o high in cycle 5 only.
- Two wait cycles per word: line_valid_o in cycle 13. word_addr_o stable during waits.
- line_req_i drops while beat 2 is pending → DRAIN. word_req_o held until rvalid, then IDLE, no line_valid_o pulse.
- Address retarget 0x1230→0x5670 during FETCH: first fill aborted without a pulse, then a fresh fill fetches 0x5670..0x567C and pulses valid.
- rstn_i asserted mid-fill: all outputs 0 immediately. After release, a new request restarts at word 0.
- With CACHE_LINE_REFILL_LINEBUF_EN: refill 0x1230 twice. The second pulse arrives in cycle 1 with the same data and zero word_req_o cycles.
